spi_master_xfer: RTL and testbench

// Mode-0 SPI master for the MCU side of the FPGA command/status link; runs the transfers the FPGA slave expects.

---
 rtl/spi_master_xfer_pkg.sv | 31 +++
 rtl/spi_sck_gen.sv | 39 +++
 rtl/spi_master_xfer.sv | 229 ++++++++++++++++++++++
 tb/tb_spi_master_xfer.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_master_xfer_pkg.sv
// Shared types and link constants for the MCU-side SPI master of the FPGA command/status link.
// The FSM state type lives here so the master and the bench agree on one encoding.
package spi_master_xfer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SETUP,
        ST_LOW,
        ST_HIGH,
        ST_HOLD,
        ST_GAP
    } state_e;

    // Link constants shared with the FPGA slave image
    localparam logic [7:0] LOGIC_VERSION      = 8'h04;
    localparam logic [7:0] CMD_STATUS         = 8'h00;
    localparam logic [7:0] CMD_MOTOR          = 8'h01;
    localparam int         CMD_MOTOR_LEN      = 12;
    localparam int         STATUS_LEN         = 17;
    localparam int         MOTOR_OFS_CMD      = 0;
    localparam int         MOTOR_OFS_SPEED    = 1;
    localparam int         STATUS_OFS_VERSION = 0;
    localparam int         STATUS_OFS_ENC1_LO = 1;
    localparam int         STATUS_OFS_ENC1_HI = 2;

    function automatic logic len_ok(input logic [4:0] len, input int max_bytes);
        return (len != 5'd0) && (int'(len) <= max_bytes);
    endfunction

endpackage

// File: rtl/spi_sck_gen.sv
// SCK half-period divider: counts sysclk cycles within the current LOW or HIGH phase
// and flags the final cycle (and, for HIGH, the cycle before it).
module spi_sck_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic sysclk,
    input  logic rst_n,
    input  logic run,
    input  logic phase_high,
    output logic end_low,
    output logic end_high,
    output logic pre_end_high
);

    logic [7:0] div_q;
    logic [7:0] div_d;
    logic       last;

    assign last         = run && (div_q == 8'(CLK_DIV - 1));
    assign end_low      = last && !phase_high;
    assign end_high     = last && phase_high;
    assign pre_end_high = run && phase_high && (div_q == 8'(CLK_DIV - 2));

    always_comb begin
        div_d = div_q + 8'd1;
        if (!run || last) begin
            div_d = 8'd0;
        end
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= 8'd0;
        end else begin
            div_q <= div_d;
        end
    end

endmodule

// File: rtl/spi_master_xfer.sv
// Mode-0 SPI master: frames a whole multi-byte transfer under one chip select, pulls each
// TX byte from the client just in time and hands back each RX byte with its index.
module spi_master_xfer
    import spi_master_xfer_pkg::*;
#(
    parameter int CLK_DIV   = 4,
    parameter int CS_SETUP  = 4,
    parameter int CS_HOLD   = 4,
    parameter int CS_IDLE   = 8,
    parameter int MAX_BYTES = 17
) (
    input  logic       sysclk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [4:0] xfer_len,
    output logic       tx_load,
    output logic [4:0] tx_index,
    input  logic [7:0] tx_data,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic [4:0] rx_index,
    output logic       busy,
    output logic       done,
    output logic       spi_ncs,
    output logic       spi_sck,
    output logic       spi_mosi,
    input  logic       spi_miso
);

    state_e     state_q, state_d;
    logic [7:0] wait_q, wait_d;
    logic [2:0] bit_q, bit_d;
    logic [4:0] byte_q, byte_d;
    logic [4:0] len_q, len_d;
    logic [6:0] tx_shift_q, tx_shift_d;
    logic [6:0] rx_shift_q, rx_shift_d;
    logic       miso_s1_q, miso_s1_d;
    logic       miso_s2_q, miso_s2_d;
    logic       mosi_q, mosi_d;
    logic       ncs_q, ncs_d;
    logic       sck_q, sck_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       tx_load_q, tx_load_d;
    logic [4:0] tx_index_q, tx_index_d;
    logic       rx_valid_q, rx_valid_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic [4:0] rx_index_q, rx_index_d;

    logic end_low, end_high, pre_end_high;
    logic last_byte;

    spi_sck_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_sck_gen (
        .sysclk      (sysclk),
        .rst_n       (rst_n),
        .run         ((state_q == ST_LOW) || (state_q == ST_HIGH)),
        .phase_high  (state_q == ST_HIGH),
        .end_low     (end_low),
        .end_high    (end_high),
        .pre_end_high(pre_end_high)
    );

    assign last_byte = (byte_q == (len_q - 5'd1));

    assign spi_ncs  = ncs_q;
    assign spi_sck  = sck_q;
    assign spi_mosi = mosi_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign tx_load  = tx_load_q;
    assign tx_index = tx_index_q;
    assign rx_valid = rx_valid_q;
    assign rx_data  = rx_data_q;
    assign rx_index = rx_index_q;

    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        bit_d      = bit_q;
        byte_d     = byte_q;
        len_d      = len_q;
        tx_shift_d = tx_shift_q;
        rx_shift_d = rx_shift_q;
        miso_s1_d  = spi_miso;
        miso_s2_d  = miso_s1_q;
        mosi_d     = mosi_q;
        done_d     = 1'b0;
        tx_load_d  = 1'b0;
        tx_index_d = tx_index_q;
        rx_valid_d = 1'b0;
        rx_data_d  = rx_data_q;
        rx_index_d = rx_index_q;

        case (state_q)
            ST_IDLE: begin
                if (start && len_ok(xfer_len, MAX_BYTES)) begin
                    state_d    = ST_LOAD;
                    len_d      = xfer_len;
                    byte_d     = 5'd0;
                    bit_d      = 3'd0;
                    tx_load_d  = 1'b1;
                    tx_index_d = 5'd0;
                end
            end
            ST_LOAD: begin
                tx_shift_d = tx_data[6:0];
                mosi_d     = tx_data[7];
                wait_d     = 8'd0;
                state_d    = ST_SETUP;
            end
            ST_SETUP: begin
                if (wait_q == 8'(CS_SETUP - 1)) begin
                    wait_d  = 8'd0;
                    state_d = ST_LOW;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            ST_LOW: begin
                if (end_low) begin
                    state_d = ST_HIGH;
                end
            end
            ST_HIGH: begin
                // Registered tx_load must be raised one cycle early so it lands on the loading edge
                if (pre_end_high && (bit_q == 3'd7) && !last_byte) begin
                    tx_load_d  = 1'b1;
                    tx_index_d = byte_q + 5'd1;
                end
                if (end_high) begin
                    rx_shift_d = {rx_shift_q[5:0], miso_s2_q};
                    if (bit_q == 3'd7) begin
                        rx_valid_d = 1'b1;
                        rx_data_d  = {rx_shift_q, miso_s2_q};
                        rx_index_d = byte_q;
                        bit_d      = 3'd0;
                        if (last_byte) begin
                            wait_d  = 8'd0;
                            state_d = ST_HOLD;
                        end else begin
                            byte_d     = byte_q + 5'd1;
                            tx_shift_d = tx_data[6:0];
                            mosi_d     = tx_data[7];
                            state_d    = ST_LOW;
                        end
                    end else begin
                        bit_d      = bit_q + 3'd1;
                        tx_shift_d = {tx_shift_q[5:0], 1'b0};
                        mosi_d     = tx_shift_q[6];
                        state_d    = ST_LOW;
                    end
                end
            end
            ST_HOLD: begin
                if (wait_q == 8'(CS_HOLD - 1)) begin
                    wait_d  = 8'd0;
                    done_d  = 1'b1;
                    state_d = ST_GAP;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            ST_GAP: begin
                // IDLE and LOAD also keep ncs high, so the gap itself is two cycles short
                if (wait_q == 8'(CS_IDLE - 3)) begin
                    wait_d  = 8'd0;
                    state_d = ST_IDLE;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ncs_d  = !((state_d == ST_SETUP) || (state_d == ST_LOW) ||
                   (state_d == ST_HIGH)  || (state_d == ST_HOLD));
        sck_d  = (state_d == ST_HIGH);
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            wait_q     <= 8'd0;
            bit_q      <= 3'd0;
            byte_q     <= 5'd0;
            len_q      <= 5'd0;
            tx_shift_q <= 7'd0;
            rx_shift_q <= 7'd0;
            miso_s1_q  <= 1'b0;
            miso_s2_q  <= 1'b0;
            mosi_q     <= 1'b0;
            ncs_q      <= 1'b1;
            sck_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            tx_load_q  <= 1'b0;
            tx_index_q <= 5'd0;
            rx_valid_q <= 1'b0;
            rx_data_q  <= 8'd0;
            rx_index_q <= 5'd0;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            bit_q      <= bit_d;
            byte_q     <= byte_d;
            len_q      <= len_d;
            tx_shift_q <= tx_shift_d;
            rx_shift_q <= rx_shift_d;
            miso_s1_q  <= miso_s1_d;
            miso_s2_q  <= miso_s2_d;
            mosi_q     <= mosi_d;
            ncs_q      <= ncs_d;
            sck_q      <= sck_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            tx_load_q  <= tx_load_d;
            tx_index_q <= tx_index_d;
            rx_valid_q <= rx_valid_d;
            rx_data_q  <= rx_data_d;
            rx_index_q <= rx_index_d;
        end
    end

endmodule

// File: tb/tb_spi_master_xfer.sv
// Directed bench for spi_master_xfer: loopback and FPGA-slave model, scoreboarded strobes,
// chip-select framing, reset abort and back-to-back restarts.
module tb_spi_master_xfer;
    import spi_master_xfer_pkg::*;

    logic       sysclk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [4:0] xfer_len;
    logic       tx_load;
    logic [4:0] tx_index;
    logic [7:0] tx_data;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic [4:0] rx_index;
    logic       busy;
    logic       done;
    logic       spi_ncs;
    logic       spi_sck;
    logic       spi_mosi;
    logic       spi_miso;

    always #5 sysclk = ~sysclk;

    spi_master_xfer dut (
        .sysclk  (sysclk),
        .rst_n   (rst_n),
        .start   (start),
        .xfer_len(xfer_len),
        .tx_load (tx_load),
        .tx_index(tx_index),
        .tx_data (tx_data),
        .rx_valid(rx_valid),
        .rx_data (rx_data),
        .rx_index(rx_index),
        .busy    (busy),
        .done    (done),
        .spi_ncs (spi_ncs),
        .spi_sck (spi_sck),
        .spi_mosi(spi_mosi),
        .spi_miso(spi_miso)
    );

    typedef struct packed {
        logic [4:0] idx;
        logic [7:0] data;
    } rx_exp_t;

    logic [7:0] tx_mem   [32];
    logic [7:0] slave_tx [32];
    logic [7:0] slave_rx [32];
    logic [7:0] rx_got   [32];
    logic [7:0] noise;
    logic       slave_miso;
    bit         loopback;

    rx_exp_t    rx_q[$];
    logic [4:0] load_q[$];
    int         gap_q[$];

    int checks, failures;
    int done_cnt, strobe_cnt, low_cnt, high_cnt, last_low_len;
    int sck_rises, last_rise_cyc, cyc, period_bad, sck_in_idle;
    int sbit, sbyte;
    logic [7:0] sshift;
    logic prev_ncs, prev_sck;

    // Client byte source: only tx_load cycles present real data, otherwise junk
    assign tx_data  = tx_load ? tx_mem[tx_index] : noise;
    assign spi_miso = loopback ? spi_mosi : slave_miso;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic pushExpect(input int n);
        rx_exp_t e;
        for (int i = 0; i < n; i++) begin
            load_q.push_back(5'(i));
            e.idx  = 5'(i);
            e.data = loopback ? tx_mem[i] : slave_tx[i];
            rx_q.push_back(e);
        end
    endtask

    task automatic pulseStart(input int len);
        @(negedge sysclk);
        start    = 1'b1;
        xfer_len = 5'(len);
        @(negedge sysclk);
        start    = 1'b0;
    endtask

    task automatic applyStimulus(input int n);
        pushExpect(n);
        pulseStart(n);
    endtask

    task automatic waitDone(input string tag, input int budget);
        int  n;
        logic got;
        n   = 0;
        got = 1'b0;
        while (n < budget && !got) begin
            @(negedge sysclk);
            if (done) got = 1'b1;
            n++;
        end
        checkOutput({tag, "_done_seen"}, 32'(got), 32'(1));
    endtask

    task automatic waitIdle(input string tag, input int budget);
        int  n;
        n = 0;
        while (n < budget && busy !== 1'b0) begin
            @(negedge sysclk);
            n++;
        end
        checkOutput({tag, "_idle_reached"}, 32'(busy), 32'(0));
        @(posedge sysclk);
        #1;
    endtask

    task automatic checkDrained(input string tag);
        checkOutput({tag, "_rx_all_seen"}, 32'(rx_q.size()), 32'(0));
        checkOutput({tag, "_loads_all_seen"}, 32'(load_q.size()), 32'(0));
    endtask

    // Behavioural FPGA slave, mode 0: shifts out on SCK fall, captures on SCK rise
    initial forever begin
        logic [7:0] cur;
        @(negedge spi_ncs);
        sbit  = 0;
        sbyte = 0;
        cur   = slave_tx[0];
        slave_miso = cur[7];
    end

    initial forever begin
        @(posedge spi_sck);
        if (spi_ncs === 1'b0) begin
            sshift = {sshift[6:0], spi_mosi};
            if (sbit == 7) begin
                if (sbyte < 32) slave_rx[sbyte] = sshift;
                sbyte++;
                sbit = 0;
            end else begin
                sbit++;
            end
        end
    end

    initial forever begin
        logic [7:0] cur;
        @(negedge spi_sck);
        if (spi_ncs === 1'b0 && sbyte < 32) begin
            cur = slave_tx[sbyte];
            slave_miso = cur[7 - sbit];
        end
    end

    // Strobe scoreboard and pin-level framing monitor, sampled mid-cycle
    initial forever begin
        rx_exp_t e;
        @(negedge sysclk);
        cyc++;
        noise = 8'($urandom);
        if (tx_load === 1'b1) begin
            strobe_cnt++;
            checkOutput("tx_load_expected", 32'(load_q.size() > 0), 32'(1));
            if (load_q.size() > 0) checkOutput("tx_index", 32'(tx_index), 32'(load_q.pop_front()));
        end
        if (rx_valid === 1'b1) begin
            strobe_cnt++;
            rx_got[rx_index] = rx_data;
            checkOutput("rx_valid_expected", 32'(rx_q.size() > 0), 32'(1));
            if (rx_q.size() > 0) begin
                e = rx_q.pop_front();
                checkOutput("rx_index", 32'(rx_index), 32'(e.idx));
                checkOutput("rx_data", 32'(rx_data), 32'(e.data));
            end
        end
        if (done === 1'b1) begin
            strobe_cnt++;
            done_cnt++;
            checkOutput("done_at_ncs_rise", 32'({prev_ncs, spi_ncs}), 32'(2'b01));
        end
        if (spi_ncs === 1'b1 && spi_sck === 1'b1) sck_in_idle++;
        if (prev_ncs === 1'b1 && spi_ncs === 1'b0) begin
            gap_q.push_back(high_cnt);
            high_cnt  = 0;
            low_cnt   = 0;
            sck_rises = 0;
        end
        if (prev_ncs === 1'b0 && spi_ncs === 1'b1) begin
            last_low_len = low_cnt;
            low_cnt      = 0;
            high_cnt     = 0;
        end
        if (spi_ncs === 1'b0) low_cnt++;
        else high_cnt++;
        if (prev_sck === 1'b0 && spi_sck === 1'b1) begin
            if (sck_rises > 0 && (cyc - last_rise_cyc) != 8) period_bad++;
            sck_rises++;
            last_rise_cyc = cyc;
        end
        prev_ncs = spi_ncs;
        prev_sck = spi_sck;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int base_done, base_strobe, n, dn;
        rst_n    = 1'b0;
        start    = 1'b0;
        xfer_len = 5'd0;
        loopback = 1'b1;
        for (int i = 0; i < 32; i++) begin
            tx_mem[i]   = 8'h00;
            slave_tx[i] = 8'h00;
            slave_rx[i] = 8'h00;
            rx_got[i]   = 8'h00;
        end

        // Reset state
        repeat (3) @(negedge sysclk);
        checkOutput("rst_ncs", 32'(spi_ncs), 32'(1));
        checkOutput("rst_sck", 32'(spi_sck), 32'(0));
        checkOutput("rst_mosi", 32'(spi_mosi), 32'(0));
        checkOutput("rst_busy", 32'(busy), 32'(0));
        checkOutput("rst_done", 32'(done), 32'(0));
        checkOutput("rst_tx_load", 32'(tx_load), 32'(0));
        checkOutput("rst_rx_valid", 32'(rx_valid), 32'(0));
        checkOutput("rst_rx_data", 32'(rx_data), 32'(0));
        checkOutput("rst_rx_index", 32'(rx_index), 32'(0));
        checkOutput("rst_tx_index", 32'(tx_index), 32'(0));
        rst_n = 1'b1;
        repeat (3) @(negedge sysclk);

        // 1: single-byte loopback
        $display("[TB] step 1: loopback N=1");
        tx_mem[0] = 8'hA5;
        base_done = done_cnt;
        applyStimulus(1);
        waitDone("t1", 2000);
        waitIdle("t1", 100);
        checkDrained("t1");
        checkOutput("t1_rx_byte", 32'(rx_got[0]), 32'(8'hA5));
        checkOutput("t1_ncs_low_len", 32'(last_low_len), 32'(72));
        checkOutput("t1_done_count", 32'(done_cnt - base_done), 32'(1));

        // 2: motor command against the slave model
        $display("[TB] step 2: motor command N=12");
        loopback = 1'b0;
        slave_tx[STATUS_OFS_VERSION] = LOGIC_VERSION;
        for (int i = 1; i < 32; i++) slave_tx[i] = 8'(8'h80 + i);
        tx_mem[MOTOR_OFS_CMD] = CMD_MOTOR;
        for (int i = MOTOR_OFS_SPEED; i < CMD_MOTOR_LEN; i++) tx_mem[i] = 8'(8'h10 + i * 7);
        period_bad = 0;
        applyStimulus(CMD_MOTOR_LEN);
        waitDone("t2", 3000);
        waitIdle("t2", 100);
        checkDrained("t2");
        checkOutput("t2_rx_version", 32'(rx_got[0]), 32'(8'h04));
        checkOutput("t2_sck_rises", 32'(sck_rises), 32'(96));
        checkOutput("t2_sck_period_errors", 32'(period_bad), 32'(0));
        checkOutput("t2_ncs_low_len", 32'(last_low_len), 32'(4 + 64 * 12 + 4));
        checkOutput("t2_slave_cmd", 32'(slave_rx[0]), 32'(CMD_MOTOR));
        for (int i = 1; i < CMD_MOTOR_LEN; i++) checkOutput("t2_slave_payload", 32'(slave_rx[i]), 32'(8'(8'h10 + i * 7)));

        // 3: full status readback
        $display("[TB] step 3: status readback N=17");
        tx_mem[0] = CMD_STATUS;
        for (int i = 1; i < 32; i++) tx_mem[i] = 8'h00;
        slave_tx[STATUS_OFS_ENC1_LO] = 8'h34;
        slave_tx[STATUS_OFS_ENC1_HI] = 8'h12;
        applyStimulus(STATUS_LEN);
        waitDone("t3", 3000);
        waitIdle("t3", 100);
        checkDrained("t3");
        checkOutput("t3_enc1_lo", 32'(rx_got[1]), 32'(8'h34));
        checkOutput("t3_enc1_hi", 32'(rx_got[2]), 32'(8'h12));
        checkOutput("t3_slave_cmd", 32'(slave_rx[0]), 32'(CMD_STATUS));

        // 4: ignored starts, during a transfer and with illegal lengths
        $display("[TB] step 4: ignored starts");
        loopback  = 1'b1;
        tx_mem[0] = 8'hC3;
        tx_mem[1] = 8'h3C;
        base_done = done_cnt;
        applyStimulus(2);
        repeat (40) @(negedge sysclk);
        pulseStart(3);
        pulseStart(0);
        pulseStart(18);
        repeat (4) @(negedge sysclk);
        checkOutput("t4_ncs_still_low", 32'(spi_ncs), 32'(0));
        waitDone("t4", 2000);
        waitIdle("t4", 100);
        checkDrained("t4");
        checkOutput("t4_done_count", 32'(done_cnt - base_done), 32'(1));
        base_strobe = strobe_cnt;
        pulseStart(0);
        pulseStart(18);
        repeat (30) @(negedge sysclk);
        checkOutput("t4_no_strobes", 32'(strobe_cnt - base_strobe), 32'(0));
        checkOutput("t4_idle_busy", 32'(busy), 32'(0));
        checkOutput("t4_idle_ncs", 32'(spi_ncs), 32'(1));

        // 5: reset abort at byte 5 bit 3
        $display("[TB] step 5: reset mid-transfer");
        for (int i = 0; i < 8; i++) tx_mem[i] = 8'(8'h21 * (i + 1));
        base_done = done_cnt;
        applyStimulus(8);
        n = 0;
        while (n < 5000 && sck_rises < 44) begin
            @(posedge sysclk);
            n++;
        end
        checkOutput("t5_reached_bit", 32'(sck_rises >= 44), 32'(1));
        @(negedge sysclk);
        rst_n = 1'b0;
        #1;
        checkOutput("t5_ncs_on_reset", 32'(spi_ncs), 32'(1));
        checkOutput("t5_sck_on_reset", 32'(spi_sck), 32'(0));
        checkOutput("t5_busy_on_reset", 32'(busy), 32'(0));
        rx_q.delete();
        load_q.delete();
        repeat (3) @(negedge sysclk);
        rst_n = 1'b1;
        repeat (5) @(negedge sysclk);
        checkOutput("t5_no_done", 32'(done_cnt - base_done), 32'(0));
        tx_mem[0] = 8'h5E;
        tx_mem[1] = 8'hE5;
        tx_mem[2] = 8'h0F;
        applyStimulus(3);
        waitDone("t5", 2000);
        waitIdle("t5", 100);
        checkDrained("t5");
        checkOutput("t5_ncs_low_len", 32'(last_low_len), 32'(4 + 64 * 3 + 4));

        // 6: start held high for three back-to-back frames
        $display("[TB] step 6: held start");
        tx_mem[0] = 8'h5A;
        tx_mem[1] = 8'h96;
        base_done = done_cnt;
        pushExpect(2);
        pushExpect(2);
        pushExpect(2);
        gap_q.delete();
        @(negedge sysclk);
        start    = 1'b1;
        xfer_len = 5'd2;
        n  = 0;
        dn = 0;
        while (n < 3000 && dn < 3) begin
            @(negedge sysclk);
            if (done) dn++;
            n++;
        end
        start = 1'b0;
        checkOutput("t6_frames", 32'(dn), 32'(3));
        waitIdle("t6", 100);
        checkDrained("t6");
        checkOutput("t6_done_count", 32'(done_cnt - base_done), 32'(3));
        checkOutput("t6_frame_starts", 32'(gap_q.size()), 32'(3));
        checkOutput("t6_gap_1", 32'(gap_q.size() > 1 ? gap_q[1] : -1), 32'(8));
        checkOutput("t6_gap_2", 32'(gap_q.size() > 2 ? gap_q[2] : -1), 32'(8));
        checkOutput("sck_high_while_deselected", 32'(sck_in_idle), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
